// File: rtl/step_pkg.sv
// Shared types and defaults for the step sequencer.
// Purely declarative: no latency or handshake of its own.
package step_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    PAUSED,
    FINISH
  } step_state_t;

  localparam int DEF_STEP_W    = 16;
  localparam int DEF_MAX_STEPS = 11;

endpackage

// File: rtl/step_watchdog.sv
// Step acknowledge watchdog (built only with STEP_SEQUENCER_WATCHDOG_EN); expire is
// combinational in the WATCHDOG-th counted cycle; clear has priority over counting.
`ifdef STEP_SEQUENCER_WATCHDOG_EN
module step_watchdog #(
  parameter int WD_W     = 8,
  parameter int WATCHDOG = 200
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  logic [WD_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + WD_W'(1);
    end
  end

  assign expire = count_en && (count == WD_W'(WATCHDOG - 1));

endmodule
`endif

// File: rtl/step_sequencer.sv
// Issues one step at a time over step/step_ack, counts steps to a limit; start to step = 2 edges.
// Backpressure: a step is held until acked; pause blocks new issues. Optional STEP_SEQUENCER_WATCHDOG_EN.
module step_sequencer
  import step_pkg::*;
#(
  parameter int STEP_W    = DEF_STEP_W,
  parameter int MAX_STEPS = DEF_MAX_STEPS
`ifdef STEP_SEQUENCER_WATCHDOG_EN
  ,
  parameter int WD_W      = 8,
  parameter int WATCHDOG  = 200
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              single,
  input  logic              pause,
  input  logic              halt,
  input  logic [STEP_W-1:0] limit,
  output logic              step,
  input  logic              step_ack,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps,
  output logic              phase,
  output logic              timeout
);

  step_state_t       state;
  step_state_t       state_nxt;
  logic [STEP_W-1:0] target;
  logic [STEP_W-1:0] steps_inc;
  logic              halt_latch;
  logic              launch;
  logic              ack_hit;
  logic              wd_expire;

  assign steps_inc = steps + STEP_W'(1);
  assign launch    = (state == IDLE) && (start || single);
  assign ack_hit   = (state == WAIT) && step_ack;

`ifdef STEP_SEQUENCER_WATCHDOG_EN
  step_watchdog #(
    .WD_W     (WD_W),
    .WATCHDOG (WATCHDOG)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (state != WAIT),
    .count_en ((state == WAIT) && !step_ack),
    .expire   (wd_expire)
  );

  // Sticky until the next launch so the host can read it after done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (launch) begin
      timeout <= 1'b0;
    end else if (wd_expire) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start || single) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (halt || halt_latch) state_nxt = FINISH;
        else if (pause)         state_nxt = PAUSED;
        else                    state_nxt = WAIT;
      end
      WAIT: begin
        // An acked step always counts, even if the watchdog fires in the same cycle.
        if (step_ack) begin
          if ((steps_inc == target) || halt_latch) state_nxt = FINISH;
          else                                     state_nxt = ISSUE;
        end else if (wd_expire) begin
          state_nxt = FINISH;
        end
      end
      PAUSED: begin
        if (halt)        state_nxt = FINISH;
        else if (!pause) state_nxt = ISSUE;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    step = (state == WAIT);
    busy = (state != IDLE);
    done = (state == FINISH);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      target <= '0;
      steps  <= '0;
      phase  <= 1'b0;
    end else if (launch) begin
      steps  <= '0;
      target <= start ? ((limit == '0) ? STEP_W'(MAX_STEPS) : limit) : STEP_W'(1);
      if (start) phase <= 1'b0;
    end else if (ack_hit) begin
      steps <= steps_inc;
      phase <= ~phase;
    end
  end

  // Halt during an outstanding step is remembered and honoured once the ack arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halt_latch <= 1'b0;
    end else if (state == FINISH) begin
      halt_latch <= 1'b0;
    end else if ((state == WAIT) && halt) begin
      halt_latch <= 1'b1;
    end
  end

endmodule
